fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that drives the word address into the instruction memory and consumes the returned instruction word. It sits between the instruction memory and the decode stage. It keeps the program counter, captures each fetched `{pc, instr}` pair into a small FIFO, and presents the pairs to decode through a valid/ready handshake. A redirect input supports branch/jump, and the FIFO absorbs decode back-pressure.

## Interface
Parameters:
- `AW`, 5: instruction memory word-address width (memory holds 2^AW words).
- `DW`, 32: instruction width.
- `DEPTH`, 2: fetch FIFO entries (power of two, ≥2).

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: one clock; reset is asynchronous and active-low (`reset`==0 resets).
- `pc`, output, AW: word address to instruction memory.
- `instr`, input, DW: instruction memory read data. It is combinational and valid in the same cycle as `pc`.
- `redirect`, input, 1: branch/jump taken this cycle.
- `redirect_pc`, input, AW: target word address, sampled when `redirect`=1.
- `if_valid`, output, 1: FIFO head holds a fetched instruction.
- `if_instr`, output, DW: instruction at the FIFO head.
- `if_pc`, output, AW: address the head instruction was fetched from.
- `if_ready`, input, 1: decode accepts the head this cycle.

## Operation
- State: PC register, FIFO storage of DEPTH × (AW+DW), read pointer, write pointer, and an occupancy counter of width clog2(DEPTH)+1.
- Handshake definitions:
  - `pop` = `if_valid` & `if_ready`.
  - `push` = `!redirect` & (count < DEPTH | pop).
  - A push while full is allowed only when a pop happens in the same cycle.
- On push:
  - The FIFO entry at the write pointer is loaded with `{pc, instr}`.
  - The write pointer increments.
  - The PC becomes PC+1 modulo 2^AW, so 31 wraps to 0 with no flag.
- No push and no redirect: the PC holds. The memory keeps being addressed with the same `pc`.
- Redirect takes priority over everything else:
  - The FIFO is flushed: count becomes 0 and both pointers reset to 0.
  - The PC becomes `redirect_pc`.
  - No push occurs that cycle.
  - A pop in the same cycle is still acknowledged to decode, but the flush discards all remaining entries.
- Count update when not redirecting: count + push − pop.
- `if_valid` = (count != 0).
- `if_instr` and `if_pc` come from the entry at the read pointer. They are 0 when the FIFO is empty.
- Pointers wrap modulo DEPTH.
- A memory output of all zeros is an ordinary instruction and has no special meaning here.

## Timing
- Reset (async assert, `reset`=0):
  - PC=0, count=0, pointers=0.
  - `pc`=0, `if_valid`=0, `if_instr`=0, `if_pc`=0.
  - Outputs take these values immediately, without waiting for a clock edge.
- Reset deassertion:
  - The first rising edge with `reset`=1 pushes mem[0].
  - `if_valid`=1 with `if_pc`=0 after that edge.
- Latency: 1 cycle from `pc` being presented to the pair appearing at the head, when the FIFO is empty.
- Throughput: one instruction per cycle while `if_ready`=1.
- Back-pressure with `if_ready`=0:
  - The FIFO fills after DEPTH edges.
  - The PC then stalls at the address of the next unfetched word.
  - No entry is dropped or duplicated.
- Redirect asserted at edge N:
  - `if_valid`=0 after edge N.
  - `pc`=`redirect_pc` after edge N.
  - The target instruction is at the head after edge N+1.
- Redirect held for several cycles: the FIFO stays empty and the PC is reloaded every cycle.
- Reset mid-stream: all state clears asynchronously, including FIFO contents and any pending redirect.

## Test plan
- Reset and stream:
  - Stimulus: hold `reset`=0, then release; `if_ready`=1; memory words 0–3 = 0x200, 0x201, 0x204, 0x108.
  - Required: all outputs 0 during reset. After successive edges, `if_pc`=0,1,2,3 with matching `if_instr`, and `if_valid` stays 1 continuously.
- Back-pressure:
  - Stimulus: `if_ready`=0 from reset.
  - Required: after 2 edges, count=2 and `pc`=2, held stable for 5 cycles. Then raise `if_ready`: pops deliver 0, 1, 2 in order with no gaps.
- Redirect:
  - Stimulus: while streaming at `pc`=5, assert `redirect` with `redirect_pc`=20 for one cycle.
  - Required: `if_valid`=0 for one cycle, then `if_pc`=20 and then 21. No word from 5–7 appears after the redirect.
- Wrap-around:
  - Stimulus: redirect to 30, then stream.
  - Required: `if_pc` sequence 30, 31, 0, 1.
- Simultaneous pop, push and full:
  - Stimulus: FIFO full with `if_ready`=1.
  - Required: push and pop both occur each cycle, count stays 2, and `pc` advances by 1 per cycle.
- Reset mid-operation:
  - Stimulus: assert `reset`=0 between clock edges while the FIFO is full.
  - Required: `if_valid`=0 and `pc`=0 immediately. After release, fetch restarts at 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction memory address/data, redirect request,
// and the valid/ready handshake towards decode.
interface fetch_unit_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          if_valid;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic          if_ready;

    modport master (
        output pc, if_valid, if_instr, if_pc,
        input  instr, redirect, redirect_pc, if_ready
    );

    modport slave (
        input  pc, if_valid, if_instr, if_pc,
        output instr, redirect, redirect_pc, if_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, captures each
// {pc, instr} pair into a small FIFO and hands it to decode.
// Redirect flushes the FIFO and reloads the PC; it wins over push.
module fetch_unit #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE   = 1;
    localparam logic [AW-1:0] PC_ONE    = 1;
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    logic [AW-1:0] pc_q;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [AW-1:0] pc_store    [DEPTH];
    logic [DW-1:0] instr_store [DEPTH];

    logic not_empty;
    logic pop;
    logic push;

    // Handshake: a full FIFO may still push when the head leaves this cycle.
    always_comb begin
        not_empty = (count != '0);
        pop       = not_empty & bus.if_ready;
        push      = !bus.redirect & ((count < CNT_DEPTH) | pop);
    end

    assign bus.pc       = pc_q;
    assign bus.if_valid = not_empty;
    assign bus.if_pc    = not_empty ? pc_store[rd_ptr]    : '0;
    assign bus.if_instr = not_empty ? instr_store[rd_ptr] : '0;

    // PC, pointers and occupancy; redirect flushes and reloads the PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect) begin
            pc_q   <= bus.redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_q   <= pc_q + PC_ONE;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; cleared on reset so no stale pair survives a restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_store[i]    <= '0;
                instr_store[i] <= '0;
            end
        end else if (push) begin
            pc_store[wr_ptr]    <= pc_q;
            instr_store[wr_ptr] <= bus.instr;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected {pc, instr}
// pairs into a scoreboard queue; a monitor compares each accepted pop.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    logic [31:0] imem [32];

    typedef struct {
        logic [4:0]  pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    fetch_unit_if #(.AW(5), .DW(32)) bus ();

    fetch_unit #(.AW(5), .DW(32), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.instr = imem[bus.pc];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int a);
        exp_t e;
        e.pc    = a[4:0];
        e.instr = imem[a];
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: inputs change just after posedge, so a pop seen at negedge
    // is the one the next rising edge commits.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.if_valid && bus.if_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got pc %0h with no expected entry at %0t", bus.if_pc, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_pc", bus.if_pc, e.pc);
                    chk("sb_instr", bus.if_instr, e.instr);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 32; a++) imem[a] = 32'hC0DE_0000 | a;
        imem[0] = 32'h200;
        imem[1] = 32'h201;
        imem[2] = 32'h204;
        imem[3] = 32'h108;
        reset           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.if_ready    = 1'b0;

        // reset state
        #7;
        chk("rst_pc", bus.pc, 0);
        chk("rst_valid", bus.if_valid, 0);
        chk("rst_instr", bus.if_instr, 0);
        chk("rst_ifpc", bus.if_pc, 0);

        // stream from reset with decode always ready
        tick();
        for (int a = 0; a < 4; a++) push_exp(a);
        reset        = 1'b1;
        bus.if_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_valid", bus.if_valid, 1);
            chk("stream_ifpc", bus.if_pc, i);
        end
        tick();
        bus.if_ready = 1'b0;
        tick();
        chk("fill_pc", bus.pc, 6);
        chk("fill_head", bus.if_pc, 4);
        tick();
        chk("stall_pc", bus.pc, 6);

        // asynchronous reset between edges while full
        #2;
        reset = 1'b0;
        #1;
        chk("mid_valid", bus.if_valid, 0);
        chk("mid_pc", bus.pc, 0);
        chk("mid_ifpc", bus.if_pc, 0);
        chk("mid_instr", bus.if_instr, 0);
        chk("mid_drain", sb.size(), 0);

        // back-pressure from reset
        tick();
        reset = 1'b1;
        tick();
        chk("bp_pc1", bus.pc, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_pc_hold", bus.pc, 2);
            chk("bp_valid", bus.if_valid, 1);
            chk("bp_head", bus.if_pc, 0);
        end

        // release: full FIFO pushes and pops each cycle
        for (int a = 0; a < 4; a++) push_exp(a);
        bus.if_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("full_pc_adv", bus.pc, 3 + k);
            chk("full_valid", bus.if_valid, 1);
        end

        // redirect to 20 while streaming at pc=5
        bus.redirect    = 1'b1;
        bus.redirect_pc = 5'd20;
        tick();
        chk("redir_valid", bus.if_valid, 0);
        chk("redir_pc", bus.pc, 20);
        chk("redir_drain", sb.size(), 0);
        bus.redirect = 1'b0;
        push_exp(20);
        push_exp(21);
        tick();
        chk("redir_head0", bus.if_pc, 20);
        tick();
        chk("redir_head1", bus.if_pc, 21);

        // redirect to 30 and stream through the wrap
        bus.redirect    = 1'b1;
        bus.redirect_pc = 5'd30;
        tick();
        chk("wrap_valid", bus.if_valid, 0);
        chk("wrap_pc", bus.pc, 30);
        chk("wrap_drain", sb.size(), 0);
        bus.redirect = 1'b0;
        push_exp(30);
        push_exp(31);
        push_exp(0);
        push_exp(1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wrap_head", bus.if_pc, (30 + i) % 32);
        end
        tick();
        bus.if_ready = 1'b0;
        tick();
        chk("end_pc", bus.pc, 4);
        tick();
        chk("end_pc_hold", bus.pc, 4);
        chk("end_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
